// File: rtl/phy_b2b_lane_channel.sv
// rtl/phy_b2b_lane_channel.sv - N-lane back-to-back PHY channel with lane skew, reversal and link FSM
// Two directions (0 = US->DS, 1 = DS->US) share one shadow config, one FSM and one error counter.
module phy_b2b_lane_channel #(
  parameter int                LANES     = 4,
  parameter int                DATA_W    = 10,
  parameter int                MAX_DLY   = 8,
  parameter logic [DATA_W-1:0] ALIGN_SYM = 10'h17C,
  parameter int                ALIGN_CNT = 4,
  parameter int                TIMEOUT   = 1024,
  localparam int               DLY_W     = $clog2(MAX_DLY + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cfg_en_i,
  input  logic                    cfg_rev_i,
  input  logic [LANES*DLY_W-1:0]  cfg_dly_i,
  input  logic [LANES*DATA_W-1:0] us_tx_data_i,
  input  logic [LANES-1:0]        us_tx_vld_i,
  output logic [LANES*DATA_W-1:0] ds_rx_data_o,
  output logic [LANES-1:0]        ds_rx_vld_o,
  input  logic [LANES*DATA_W-1:0] ds_tx_data_i,
  input  logic [LANES-1:0]        ds_tx_vld_i,
  output logic [LANES*DATA_W-1:0] us_rx_data_o,
  output logic [LANES-1:0]        us_rx_vld_o,
  output logic [1:0]              link_state_o,
  output logic                    link_up_o,
  output logic [7:0]              retry_cnt_o,
  output logic [15:0]             err_cnt_o
);
  localparam int NSTG = MAX_DLY + 1;
  localparam int ACW  = $clog2(ALIGN_CNT + 1);
  localparam int TCW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_DOWN = 2'd0, ST_ALIGN = 2'd1, ST_UP = 2'd2} state_e;

  state_e            state_q, state_d;
  logic              rev_q, rev_d;
  logic [DLY_W-1:0]  dly_q [LANES];
  logic [DLY_W-1:0]  dly_d [LANES];
  logic [DATA_W-1:0] dat_q [2][LANES][NSTG];
  logic [NSTG-1:0]   vld_q [2][LANES];
  logic [DATA_W-1:0] in_dat [2][LANES];
  logic [LANES-1:0]  in_vld [2];
  logic [DATA_W-1:0] tap_dat [2][LANES];
  logic [LANES-1:0]  tap_vld [2];
  logic [ACW-1:0]    acnt_q [2][LANES];
  logic [ACW-1:0]    acnt_upd [2][LANES];
  logic [TCW-1:0]    tmr_q;
  logic [7:0]        retry_q;
  logic [15:0]       err_q;
  logic [1:0]        mis;
  logic [16:0]       err_sum;
  logic              all_aligned, timeout, enter_align, flush;

  assign timeout     = (state_q == ST_ALIGN) && (tmr_q == TCW'(TIMEOUT - 1));
  assign enter_align = (state_q == ST_DOWN) && (state_d == ST_ALIGN);
  // Flushing on either side of DOWN drops both in-flight and newly offered symbols.
  assign flush       = (state_q == ST_DOWN) || (state_d == ST_DOWN);

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_DOWN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DOWN:  if (cfg_en_i) state_d = ST_ALIGN;
      ST_ALIGN: begin
        if (!cfg_en_i || timeout) state_d = ST_DOWN;
        else if (all_aligned)     state_d = ST_UP;
      end
      ST_UP:    if (!cfg_en_i) state_d = ST_DOWN;
      default:  state_d = ST_DOWN;
    endcase
  end

  always_comb begin
    link_state_o = state_q;
    link_up_o    = (state_q == ST_UP);
    retry_cnt_o  = retry_q;
    err_cnt_o    = err_q;
    ds_rx_data_o = '0;
    us_rx_data_o = '0;
    ds_rx_vld_o  = tap_vld[0];
    us_rx_vld_o  = tap_vld[1];
    for (int j = 0; j < LANES; j++) begin
      ds_rx_data_o[j*DATA_W +: DATA_W] = tap_dat[0][j];
      us_rx_data_o[j*DATA_W +: DATA_W] = tap_dat[1][j];
    end
  end

  always_comb begin
    logic [DLY_W-1:0] raw;
    raw   = '0;
    rev_d = enter_align ? cfg_rev_i : rev_q;
    dly_d = dly_q;
    for (int j = 0; j < LANES; j++) begin
      raw = cfg_dly_i[j*DLY_W +: DLY_W];
      if (enter_align) dly_d[j] = (raw > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : raw;
    end
  end

  // Delay lines are indexed by destination lane; reversal is applied at the input.
  always_comb begin
    int src;
    src    = 0;
    in_dat = '{default: '0};
    in_vld = '{default: '0};
    for (int j = 0; j < LANES; j++) begin
      src          = rev_q ? (LANES - 1 - j) : j;
      in_dat[0][j] = us_tx_data_i[src*DATA_W +: DATA_W];
      in_vld[0][j] = us_tx_vld_i[src];
      in_dat[1][j] = ds_tx_data_i[src*DATA_W +: DATA_W];
      in_vld[1][j] = ds_tx_vld_i[src];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < LANES; j++) begin
        if (rst_i || flush) begin
          vld_q[d][j] <= '0;
          for (int k = 0; k < NSTG; k++) dat_q[d][j][k] <= '0;
        end else begin
          vld_q[d][j]    <= {vld_q[d][j][NSTG-2:0], in_vld[d][j]};
          dat_q[d][j][0] <= in_dat[d][j];
          for (int k = 1; k < NSTG; k++) dat_q[d][j][k] <= dat_q[d][j][k-1];
        end
      end
    end
  end

  always_comb begin
    tap_dat     = '{default: '0};
    tap_vld     = '{default: '0};
    acnt_upd    = acnt_q;
    all_aligned = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < LANES; j++) begin
        tap_dat[d][j] = dat_q[d][j][dly_q[j]];
        tap_vld[d][j] = vld_q[d][j][dly_q[j]];
        if (tap_vld[d][j]) begin
          if (tap_dat[d][j] != ALIGN_SYM)           acnt_upd[d][j] = '0;
          else if (acnt_q[d][j] < ACW'(ALIGN_CNT)) acnt_upd[d][j] = acnt_q[d][j] + 1'b1;
        end
        if (acnt_upd[d][j] < ACW'(ALIGN_CNT)) all_aligned = 1'b0;
      end
    end
    for (int d = 0; d < 2; d++) mis[d] = (|tap_vld[d]) && !(&tap_vld[d]);
    err_sum = {1'b0, err_q} + {15'd0, 2'({1'b0, mis[0]}) + 2'({1'b0, mis[1]})};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rev_q   <= 1'b0;
      dly_q   <= '{default: '0};
      acnt_q  <= '{default: '0};
      tmr_q   <= '0;
      retry_q <= '0;
      err_q   <= '0;
    end else begin
      rev_q  <= rev_d;
      dly_q  <= dly_d;
      acnt_q <= enter_align ? '{default: '0} : acnt_upd;
      tmr_q  <= (state_q == ST_ALIGN) ? tmr_q + 1'b1 : '0;
      if (timeout && cfg_en_i && retry_q != 8'hFF) retry_q <= retry_q + 1'b1;
      if (state_q == ST_UP) err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule
